// File: rtl/btree_node_search.sv
// Single B-tree node key store with a sequential, one-key-per-clock search engine.
// Reports exact match or insertion point for the downstream compare/branch stage.
module btree_node_search #(
   parameter int KEYS  = 4,
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             wrEn,
   input  logic [IDX_W-1:0] wrIndex,
   input  logic [WIDTH-1:0] wrKey,
   input  logic             cntEn,
   input  logic [IDX_W-1:0] cntValue,
   input  logic             start,
   input  logic [WIDTH-1:0] searchKey,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [IDX_W-1:0] index,
   output logic [IDX_W-1:0] comparisons
);

   localparam logic [IDX_W-1:0] MAX_COUNT = IDX_W'(KEYS);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] keys [KEYS];
   logic [IDX_W-1:0] count;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_inc;
   logic [WIDTH-1:0] key_q;
   logic [WIDTH-1:0] cur_key;

   logic             accept;
   logic             term;
   logic             term_found;
   logic [IDX_W-1:0] term_index;
   logic [IDX_W-1:0] term_cmp;

   // State register
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = SCAN;
         SCAN: if (term)   state_nx = IDLE;
         default:          state_nx = IDLE;
      endcase
   end

   // Key under the scan pointer; an explicit mux keeps the pointer width independent of KEYS.
   always_comb begin
      cur_key = '0;
      for (int k = 0; k < KEYS; k++) begin
         if (ptr == IDX_W'(k)) cur_key = keys[k];
      end
   end

   assign ptr_inc = ptr + 1'b1;

   // Output/decision logic: one comparison per SCAN edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path through this block infers a latch.
      accept     = (state == IDLE) && start;
      term       = 1'b0;
      term_found = 1'b0;
      term_index = '0;
      term_cmp   = ptr_inc;
      if (state == SCAN) begin
         if (count == '0) begin
            term     = 1'b1;
            term_cmp = '0;
         end else if (cur_key == key_q) begin
            term       = 1'b1;
            term_found = 1'b1;
            term_index = ptr;
         end else if (cur_key > key_q) begin
            term       = 1'b1;
            term_index = ptr;
         end else if (ptr_inc == count) begin
            term       = 1'b1;
            term_index = count;
         end
      end
   end

   // Node contents; writes are only honoured while idle, and land before a coincident search.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         // NOTE: the key array is deliberately reset; a freshly reset node must read as all-zero keys.
         for (int k = 0; k < KEYS; k++) keys[k] <= '0;
         count <= '0;
      end else if (state == IDLE) begin
         for (int k = 0; k < KEYS; k++) begin
            if (wrEn && (wrIndex == IDX_W'(k))) keys[k] <= wrKey;
         end
         if (cntEn) count <= (cntValue > MAX_COUNT) ? MAX_COUNT : cntValue;
      end
   end

   // Scan datapath and result registers.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         key_q       <= '0;
         ptr         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         index       <= '0;
         comparisons <= '0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            key_q       <= searchKey;
            ptr         <= '0;
            comparisons <= '0;
            busy        <= 1'b1;
         end else if (state == SCAN) begin
            if (term) begin
               busy        <= 1'b0;
               done        <= 1'b1;
               found       <= term_found;
               index       <= term_index;
               comparisons <= term_cmp;
            end else begin
               ptr         <= ptr_inc;
               comparisons <= ptr_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_btree_node_search.sv
// Directed bench for btree_node_search: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops and compares on every done pulse.
module tb_btree_node_search;

   localparam int KEYS  = 4;
   localparam int WIDTH = 8;
   localparam int IDX_W = 3;

   logic             clock;
   logic             resetN;
   logic             wrEn;
   logic [IDX_W-1:0] wrIndex;
   logic [WIDTH-1:0] wrKey;
   logic             cntEn;
   logic [IDX_W-1:0] cntValue;
   logic             start;
   logic [WIDTH-1:0] searchKey;
   logic             busy;
   logic             done;
   logic             found;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] comparisons;

   typedef struct {
      int f;
      int idx;
      int cmp;
      int lat;
      int start_cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   btree_node_search #(.KEYS(KEYS), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clock       (clock),
      .resetN      (resetN),
      .wrEn        (wrEn),
      .wrIndex     (wrIndex),
      .wrKey       (wrKey),
      .cntEn       (cntEn),
      .cntValue    (cntValue),
      .start       (start),
      .searchKey   (searchKey),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .index       (index),
      .comparisons (comparisons)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("found", int'(found), mon_e.f);
            check("index", int'(index), mon_e.idx);
            check("comparisons", int'(comparisons), mon_e.cmp);
            check("latency", cyc - mon_e.start_cyc, mon_e.lat);
            check("busy_at_done", int'(busy), 0);
         end
      end
   end

   task automatic push_exp(input int f, input int idx, input int cmp, input int lat);
      exp_t e;
      e.f = f; e.idx = idx; e.cmp = cmp; e.lat = lat; e.start_cyc = cyc;
      sb.push_back(e);
   endtask

   task automatic launch(input logic [WIDTH-1:0] k, input int f, input int idx,
                         input int cmp, input int lat);
      @(negedge clock);
      start     = 1'b1;
      searchKey = k;
      @(posedge clock);
      #1;
      push_exp(f, idx, cmp, lat);
      start = 1'b0;
   endtask

   // Waits for the pending result, checking busy stays high meanwhile; bounded.
   task automatic wait_done();
      int n;
      n = 0;
      forever begin
         @(negedge clock);
         if (done === 1'b1) break;
         check("busy_while_scanning", int'(busy), 1);
         n++;
         if (n > 20) begin
            check("done_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic search(input logic [WIDTH-1:0] k, input int f, input int idx,
                         input int cmp, input int lat);
      launch(k, f, idx, cmp, lat);
      wait_done();
   endtask

   task automatic write_key(input int slot, input logic [WIDTH-1:0] v);
      @(negedge clock);
      wrEn    = 1'b1;
      wrIndex = IDX_W'(slot);
      wrKey   = v;
      @(posedge clock);
      #1;
      wrEn = 1'b0;
   endtask

   task automatic set_count(input int v);
      @(negedge clock);
      cntEn    = 1'b1;
      cntValue = IDX_W'(v);
      @(posedge clock);
      #1;
      cntEn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetN = 1'b0; wrEn = 1'b0; wrIndex = '0; wrKey = '0;
      cntEn = 1'b0; cntValue = '0; start = 1'b0; searchKey = '0;
      repeat (2) @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_found", int'(found), 0);
      check("rst_index", int'(index), 0);
      check("rst_comparisons", int'(comparisons), 0);
      resetN = 1'b1;

      write_key(0, 8'd10);
      write_key(1, 8'd20);
      write_key(2, 8'd30);
      write_key(3, 8'd40);
      set_count(4);

      search(8'd30, 1, 2, 3, 3);
      search(8'd25, 0, 2, 3, 3);
      search(8'd5,  0, 0, 1, 1);
      search(8'd50, 0, 4, 4, 4);
      search(8'd40, 1, 3, 4, 4);

      set_count(0);
      search(8'd7, 0, 0, 0, 1);

      set_count(7);
      search(8'd99, 0, 4, 4, 4);

      // Write coinciding with start must be visible to that scan: keys become 10,20,20,30.
      write_key(3, 8'd30);
      @(negedge clock);
      wrEn = 1'b1; wrIndex = 3'd2; wrKey = 8'd20;
      start = 1'b1; searchKey = 8'd25;
      @(posedge clock);
      #1;
      push_exp(0, 3, 4, 4);
      wrEn = 1'b0; start = 1'b0;
      wait_done();

      search(8'd20, 1, 1, 2, 2);

      // Out-of-range slot must not alias onto slot 1.
      write_key(2, 8'd30);
      write_key(3, 8'd40);
      write_key(5, 8'd1);
      search(8'd20, 1, 1, 2, 2);

      // Start/wrEn/cntEn while busy are all ignored.
      launch(8'd50, 0, 4, 4, 4);
      @(negedge clock);
      start = 1'b1; searchKey = 8'd10;
      wrEn = 1'b1; wrIndex = 3'd0; wrKey = 8'd99;
      cntEn = 1'b1; cntValue = 3'd1;
      @(posedge clock);
      #1;
      start = 1'b0; wrEn = 1'b0; cntEn = 1'b0;
      wait_done();
      search(8'd10, 1, 0, 1, 1);

      // Start held high: ignored on the done edge, accepted on the following one.
      @(negedge clock);
      start = 1'b1; searchKey = 8'd5;
      @(posedge clock);
      #1;
      push_exp(0, 0, 1, 1);
      @(posedge clock);
      @(posedge clock);
      #1;
      push_exp(0, 0, 1, 1);
      start = 1'b0;
      wait_done();

      // Reset in the middle of a search-40 scan: immediate clear, no done pulse.
      launch(8'd40, 1, 3, 4, 4);
      @(negedge clock);
      @(negedge clock);
      check("busy_before_abort", int'(busy), 1);
      resetN = 1'b0;
      sb.delete();
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_found", int'(found), 0);
      check("abort_index", int'(index), 0);
      check("abort_comparisons", int'(comparisons), 0);
      repeat (2) @(negedge clock);
      resetN = 1'b1;
      repeat (3) @(negedge clock);
      check("no_done_after_abort", int'(done), 0);

      set_count(4);
      search(8'd0, 1, 0, 1, 1);

      repeat (3) @(negedge clock);
      check("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
